// File: rtl/lfsr_prng_pkg.sv
// Shared definitions for the lfsr_prng generator: FSM encoding, feedback
// mode constants and a maximal-length tap table for widths 3..32.
package lfsr_prng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam bit MODE_FIB    = 1'b0;
  localparam bit MODE_GALOIS = 1'b1;

  // Bit i set = state bit i tapped; Fibonacci form, feedback into bit 0.
  function automatic logic [31:0] max_taps(input int unsigned w);
    case (w)
      3:       max_taps = 32'h0000_0006;
      4:       max_taps = 32'h0000_000C;
      5:       max_taps = 32'h0000_0014;
      6:       max_taps = 32'h0000_0030;
      7:       max_taps = 32'h0000_0060;
      8:       max_taps = 32'h0000_00B8;
      9:       max_taps = 32'h0000_0110;
      10:      max_taps = 32'h0000_0240;
      11:      max_taps = 32'h0000_0500;
      12:      max_taps = 32'h0000_0829;
      13:      max_taps = 32'h0000_100D;
      14:      max_taps = 32'h0000_2015;
      15:      max_taps = 32'h0000_6000;
      16:      max_taps = 32'h0000_D008;
      17:      max_taps = 32'h0001_2000;
      18:      max_taps = 32'h0002_0400;
      19:      max_taps = 32'h0004_0023;
      20:      max_taps = 32'h0009_0000;
      21:      max_taps = 32'h0014_0000;
      22:      max_taps = 32'h0030_0000;
      23:      max_taps = 32'h0042_0000;
      24:      max_taps = 32'h00E1_0000;
      25:      max_taps = 32'h0120_0000;
      26:      max_taps = 32'h0200_0023;
      27:      max_taps = 32'h0400_0013;
      28:      max_taps = 32'h0900_0000;
      29:      max_taps = 32'h1400_0000;
      30:      max_taps = 32'h2000_0029;
      31:      max_taps = 32'h4800_0000;
      32:      max_taps = 32'h8020_0003;
      default: max_taps = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_prng_step.sv
// One combinational LFSR shift, Fibonacci or Galois form selected by GALOIS.
module lfsr_step
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned           WIDTH  = 8,
  parameter logic [WIDTH-1:0]      TAPS   = 'hB8,
  parameter bit                    GALOIS = MODE_FIB
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_next
);

  generate
    if (GALOIS == MODE_GALOIS) begin : g_galois
      // Shift left with the MSB wrapping into bit 0, then fold in taps.
      assign s_next = {s[WIDTH-2:0], s[WIDTH-1]} ^ (s[WIDTH-1] ? TAPS : '0);
    end else begin : g_fib
      assign s_next = {s[WIDTH-2:0], ^(s & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised LFSR PRNG with seed load, enable and valid/ready output.
// Define LFSR_PERIOD_CHECK_EN to add the period_done/period_len checker.
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 'hB8,
  parameter bit               GALOIS       = MODE_FIB,
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LFSR_PERIOD_CHECK_EN
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
`endif
  output logic             lockup_err
);

  fsm_t                     fsm;
  logic [WIDTH-1:0]         state;
  logic [STEPS:0][WIDTH-1:0] chain;
  logic                     adv;
  logic                     zero_seed;
  logic [WIDTH-1:0]         seed_val;

  assign chain[0] = state;

  generate
    for (genvar g = 0; g < STEPS; g++) begin : g_step
      lfsr_step #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
      ) u_step (
        .s      (chain[g]),
        .s_next (chain[g+1])
      );
    end
  endgenerate

  assign out_data  = state;
  assign zero_seed = (seed_in == '0);
  assign seed_val  = zero_seed ? SEED_DEFAULT : seed_in;
  assign adv       = (fsm == RUN) && out_valid && out_ready;

  // out_valid tracks the next FSM state, forced low for the cycle after a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state      <= SEED_DEFAULT;
      out_valid  <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      lockup_err <= seed_load && zero_seed;
      case (fsm)
        IDLE:    if (enable)  fsm <= RUN;
        RUN:     if (!enable) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
      out_valid <= enable && !seed_load;
      if (seed_load)
        state <= seed_val;
      else if (adv)
        state <= chain[STEPS];
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  logic [WIDTH-1:0] seed_ref;
  logic [WIDTH-1:0] adv_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_ref    <= SEED_DEFAULT;
      adv_cnt     <= '0;
      period_done <= 1'b0;
      period_len  <= '0;
    end else begin
      period_done <= 1'b0;
      if (seed_load) begin
        seed_ref <= seed_val;
        adv_cnt  <= '0;
      end else if (adv) begin
        if (chain[STEPS] == seed_ref) begin
          period_done <= 1'b1;
          period_len  <= adv_cnt + 1'b1;
          adv_cnt     <= '0;
        end else begin
          adv_cnt <= adv_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: 8-bit Fibonacci default instance plus a
// 16-bit Galois STEPS=4 instance checked against a reference model.
module tb_lfsr_prng;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, seed_load, out_ready;
  logic [7:0]  seed_in, out_data;
  logic        out_valid, lockup_err;
`ifdef LFSR_PERIOD_CHECK_EN
  logic        period_done;
  logic [7:0]  period_len;
`endif

  logic        enable_g, seed_load_g, out_ready_g;
  logic [15:0] seed_in_g, out_data_g;
  logic        out_valid_g, lockup_err_g;
`ifdef LFSR_PERIOD_CHECK_EN
  logic        period_done_g;
  logic [15:0] period_len_g;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef LFSR_PERIOD_CHECK_EN
    .period_done(period_done),
    .period_len (period_len),
`endif
    .lockup_err (lockup_err)
  );

  lfsr_prng #(
    .WIDTH        (16),
    .TAPS         (16'hB400),
    .GALOIS       (1'b1),
    .STEPS        (4),
    .SEED_DEFAULT (16'h0001)
  ) dut_g (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable_g),
    .seed_load  (seed_load_g),
    .seed_in    (seed_in_g),
    .out_data   (out_data_g),
    .out_valid  (out_valid_g),
    .out_ready  (out_ready_g),
`ifdef LFSR_PERIOD_CHECK_EN
    .period_done(period_done_g),
    .period_len (period_len_g),
`endif
    .lockup_err (lockup_err_g)
  );

  function automatic logic [15:0] gal_ref(input logic [15:0] s);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'hB400;
    t[0] = t[0] ^ s[15];
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  fib_exp [5];
    logic [15:0] m;
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = 8'h00; out_ready = 1'b0;
    enable_g = 1'b0; seed_load_g = 1'b0; seed_in_g = 16'h0000; out_ready_g = 1'b0;
    fib_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    repeat (2) tick();
    check("rst_data",   32'(out_data), 32'h01);
    check("rst_valid",  32'(out_valid), 32'h0);
    check("rst_lockup", 32'(lockup_err), 32'h0);
    check("rst_data_g", 32'(out_data_g), 32'h0001);
    rst = 1'b0;

    // Stream from reset seed
    enable = 1'b1; out_ready = 1'b1;
    tick();
    check("run_first_data",  32'(out_data), 32'h01);
    check("run_first_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run_seq", 32'(out_data), 32'(fib_exp[i]));
    end

    // Back-pressure at 8'h23
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data",  32'(out_data), 32'h23);
      check("stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check("resume_data", 32'(out_data), 32'h47);

    // Zero seed load while advancing: load wins, lock-up flagged
    seed_load = 1'b1; seed_in = 8'h00;
    tick();
    seed_load = 1'b0;
    check("zseed_data",   32'(out_data), 32'h01);
    check("zseed_lockup", 32'(lockup_err), 32'h1);
    check("zseed_valid",  32'(out_valid), 32'h0);
    tick();
    check("zseed_lockup_clr", 32'(lockup_err), 32'h0);
    check("zseed_valid_back", 32'(out_valid), 32'h1);
    check("zseed_hold",       32'(out_data), 32'h01);
    tick();
    check("zseed_adv", 32'(out_data), 32'h02);

    // Load with enable low stays idle
    out_ready = 1'b0; enable = 1'b0;
    tick();
    check("idle_valid", 32'(out_valid), 32'h0);
    seed_load = 1'b1; seed_in = 8'h5A;
    tick();
    seed_load = 1'b0;
    check("idle_load_data",   32'(out_data), 32'h5A);
    check("idle_load_valid",  32'(out_valid), 32'h0);
    check("idle_load_lockup", 32'(lockup_err), 32'h0);
    out_ready = 1'b1;
    repeat (2) tick();
    check("idle_hold_data",  32'(out_data), 32'h5A);
    check("idle_hold_valid", 32'(out_valid), 32'h0);
    enable = 1'b1;
    tick();
    check("reen_valid", 32'(out_valid), 32'h1);
    check("reen_data",  32'(out_data), 32'h5A);
    tick();
    check("seed5a_s1", 32'(out_data), 32'hB4);
    tick();
    check("seed5a_s2", 32'(out_data), 32'h69);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data",  32'(out_data), 32'h01);
    tick();
    rst = 1'b0;

    // Galois 16-bit, 4 shifts per transfer
    enable_g = 1'b1; out_ready_g = 1'b1; seed_load_g = 1'b1; seed_in_g = 16'hACE1;
    tick();
    seed_load_g = 1'b0;
    check("gal_load_data",  32'(out_data_g), 32'hACE1);
    check("gal_load_valid", 32'(out_valid_g), 32'h0);
    tick();
    check("gal_valid", 32'(out_valid_g), 32'h1);
    check("gal_first", 32'(out_data_g), 32'hACE1);
    m = 16'hACE1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      for (int k = 0; k < 4; k++) m = gal_ref(m);
      check("gal_seq", 32'(out_data_g), 32'(m));
    end
    enable_g = 1'b0;

`ifdef LFSR_PERIOD_CHECK_EN
    begin
      int adv_n;
      logic vb;
      adv_n = 0;
      enable = 1'b1; out_ready = 1'b1; seed_load = 1'b1; seed_in = 8'h01;
      tick();
      seed_load = 1'b0;
      for (int i = 0; i < 300; i++) begin
        vb = out_valid;
        tick();
        if (vb) adv_n++;
        if (period_done) break;
      end
      check("period_done", 32'(period_done), 32'h1);
      check("period_advs", 32'(adv_n), 32'd255);
      check("period_len",  32'(period_len), 32'd255);
      check("period_data", 32'(out_data), 32'h01);
      tick();
      check("period_pulse", 32'(period_done), 32'h0);
      check("period_hold",  32'(period_len), 32'd255);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
